sample_feeder: RTL and testbench

Transmit end of the sample-feed interface consumed by the acquisition/tracking top. It buffers a block of IF samples loaded by a host or testbench, then replays them as clk_sample/feed_reset/feed_complete/data, in the framing the receiver's synchronizers and memory bank expect. It supports both high-speed mode (one sample per clk) and strobed mode (one sample per DIV clks, with a toggling clk_sample). Used for FPGA self-test and loopback of acquisition.

---
 rtl/sample_feeder.sv | 161 ++++++++++++++++
 tb/tb_sample_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// Sample feeder: buffers a block of IF samples, then replays them with framing.
// Latency: start at edge t -> busy from t+1, sample 0 from t+2, done at t+2+N*DIV.
// No backpressure: the receiver must take every sample; host inputs are ignored while busy.
module sample_feeder #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DIV    = 1
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              load_clear,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_data,
  output logic [ADDR_W:0]   load_count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              clk_sample,
  output logic              feed_reset,
  output logic              feed_complete,
  output logic [WIDTH-1:0]  data
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Phase counter sizing; DIV=1 still keeps a 1-bit counter that stays at 0
  localparam int             PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  P_HALF = PW'(DIV / 2);
  localparam logic [PW-1:0]  P_ONE  = PW'(1);
  localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE = (ADDR_W + 1)'(1);

  logic [1:0]        state;
  logic [ADDR_W:0]   n_last;     // index of the final sample, latched at start
  logic [ADDR_W:0]   k;          // sample currently on the outputs
  logic [PW-1:0]     p;          // phase within the current sample period
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W:0]   k_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_period;
  logic              last_sample;
  logic              wr_ok;
  logic              rd_en;

  // Sample clock level for a given phase: high for the first half of the period,
  // constantly high in high-speed mode.
  function automatic logic clk_phase(input logic [PW-1:0] ph);
    if (DIV == 1) return 1'b1;
    return (ph < P_HALF);
  endfunction

  // Control decode; the read is prefetched on the last phase of each period
  // so that the next sample lands in the output register with no gap.
  always_comb begin
    k_nxt       = k + C_ONE;
    last_period = (p == P_LAST);
    last_sample = (k == n_last);
    rd_addr     = (state == S_PRIME) ? '0 : k_nxt[ADDR_W-1:0];
    wr_ok       = (state == S_IDLE) && load_en && !load_clear && (load_count != FULL);
    rd_en       = (state == S_PRIME) ||
                  ((state == S_PLAY) && last_period && !last_sample);
  end

  // Sample buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_ok) mem[load_count[ADDR_W-1:0]] <= load_data;
  end

  // Registered read port doubles as the data output register
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      data <= '0;
    end else if (rd_en) begin
      data <= mem[rd_addr];
    end else if ((state == S_PLAY) && last_period) begin
      data <= '0;
    end
  end

  // Load counter: clear wins over a write; frozen outside IDLE
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      load_count <= '0;
    end else if (state == S_IDLE) begin
      if (load_clear)  load_count <= '0;
      else if (wr_ok)  load_count <= load_count + C_ONE;
    end
  end

  // Playback sequencer and registered framing outputs
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      clk_sample    <= 1'b0;
      feed_reset    <= 1'b0;
      feed_complete <= 1'b0;
      n_last        <= '0;
      k             <= '0;
      p             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && (load_count != '0)) begin
            state  <= S_PRIME;
            busy   <= 1'b1;
            n_last <= load_count - C_ONE;
          end
        end
        S_PRIME: begin
          state         <= S_PLAY;
          k             <= '0;
          p             <= '0;
          feed_reset    <= 1'b1;
          feed_complete <= (n_last == '0);
          clk_sample    <= clk_phase('0);
        end
        S_PLAY: begin
          if (last_period) begin
            if (last_sample) begin
              state         <= S_DONE;
              busy          <= 1'b0;
              done          <= 1'b1;
              clk_sample    <= 1'b0;
              feed_reset    <= 1'b0;
              feed_complete <= 1'b0;
            end else begin
              k             <= k_nxt;
              p             <= '0;
              feed_reset    <= 1'b0;
              feed_complete <= (k_nxt == n_last);
              clk_sample    <= clk_phase('0);
            end
          end else begin
            p          <= p + P_ONE;
            clk_sample <= clk_phase(p + P_ONE);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: one high-speed instance and one DIV=4 instance.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// All expected values are hand-derived constants.
module tb_sample_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        global_reset;
  logic        load_clear;
  logic        load_en;
  logic [2:0]  load_data;
  logic        start1;
  logic        start4;

  logic [12:0] lc1, lc4;
  logic        busy1, done1, cs1, fr1, fc1;
  logic        busy4, done4, cs4, fr4, fc4;
  logic [2:0]  d1, d4;

  int total = 0;
  int bad   = 0;

  // Expected sequence for a 4-sample high-speed playback (cycles t+2..t+6)
  int exp_d [5]  = '{1, 2, 3, 4, 0};
  int exp_fr[5]  = '{1, 0, 0, 0, 0};
  int exp_fc[5]  = '{0, 0, 0, 1, 0};
  int exp_dn[5]  = '{0, 0, 0, 0, 1};
  int exp_bz[5]  = '{1, 1, 1, 1, 0};
  int exp_cs4[4] = '{1, 1, 0, 0};

  sample_feeder #(.WIDTH(3), .DEPTH(4096), .ADDR_W(12), .DIV(1)) u1 (
    .clk(clk), .global_reset(global_reset), .load_clear(load_clear),
    .load_en(load_en), .load_data(load_data), .load_count(lc1),
    .start(start1), .busy(busy1), .done(done1), .clk_sample(cs1),
    .feed_reset(fr1), .feed_complete(fc1), .data(d1)
  );

  sample_feeder #(.WIDTH(3), .DEPTH(4096), .ADDR_W(12), .DIV(4)) u4 (
    .clk(clk), .global_reset(global_reset), .load_clear(load_clear),
    .load_en(load_en), .load_data(load_data), .load_count(lc4),
    .start(start4), .busy(busy4), .done(done4), .clk_sample(cs4),
    .feed_reset(fr4), .feed_complete(fc4), .data(d4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [2:0] v);
    load_en   = 1'b1;
    load_data = v;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic clear_all();
    load_clear = 1'b1;
    tick();
    load_clear = 1'b0;
  endtask

  // Plays samples 1,2,3,4 on the DIV=1 instance; optionally pokes the host
  // inputs mid-playback, which must have no effect.
  task automatic play4(input string tag, input bit inject);
    int extra;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq({tag, " prime busy"}, busy1, 1);
    check_eq({tag, " prime data"}, d1, 0);
    check_eq({tag, " prime cs"}, cs1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      start1 = 1'b0; load_en = 1'b0; load_clear = 1'b0;
      check_eq($sformatf("%s data[%0d]", tag, i), d1, exp_d[i]);
      check_eq($sformatf("%s fr[%0d]", tag, i), fr1, exp_fr[i]);
      check_eq($sformatf("%s fc[%0d]", tag, i), fc1, exp_fc[i]);
      check_eq($sformatf("%s done[%0d]", tag, i), done1, exp_dn[i]);
      check_eq($sformatf("%s busy[%0d]", tag, i), busy1, exp_bz[i]);
      check_eq($sformatf("%s cs[%0d]", tag, i), cs1, exp_bz[i]);
      check_eq($sformatf("%s lc[%0d]", tag, i), lc1, 4);
      if (inject && i == 1) begin
        start1 = 1'b1; load_en = 1'b1; load_data = 3'd7; load_clear = 1'b1;
      end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done1 || busy1) extra++;
    end
    check_eq({tag, " no second done"}, extra, 0);
  endtask

  initial begin
    int seen;
    global_reset = 1'b1;
    load_clear = 1'b0; load_en = 1'b0; load_data = '0;
    start1 = 1'b0; start4 = 1'b0;
    tick();
    check_eq("rst lc1", lc1, 0);
    check_eq("rst busy1", busy1, 0);
    check_eq("rst done1", done1, 0);
    check_eq("rst outs1", {cs1, fr1, fc1, d1}, 0);
    check_eq("rst outs4", {busy4, done4, cs4, fr4, fc4, d4}, 0);
    global_reset = 1'b0;
    tick();

    // High-speed, four samples
    clear_all();
    load_one(3'd1); load_one(3'd2); load_one(3'd3); load_one(3'd4);
    check_eq("t1 lc", lc1, 4);
    play4("t1", 1'b0);

    // Strobed DIV=4, two samples
    clear_all();
    load_one(3'd5); load_one(3'd6);
    check_eq("t2 lc4", lc4, 2);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check_eq("t2 prime busy", busy4, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("t2 data[%0d]", i), d4, (i < 4) ? 5 : 6);
      check_eq($sformatf("t2 fr[%0d]", i), fr4, (i < 4) ? 1 : 0);
      check_eq($sformatf("t2 fc[%0d]", i), fc4, (i < 4) ? 0 : 1);
      check_eq($sformatf("t2 cs[%0d]", i), cs4, exp_cs4[i % 4]);
      check_eq($sformatf("t2 done[%0d]", i), done4, 0);
    end
    tick();
    check_eq("t2 done", done4, 1);
    check_eq("t2 busy end", busy4, 0);
    check_eq("t2 data end", d4, 0);

    // Single sample
    clear_all();
    load_one(3'd7);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check_eq("t3 data", d1, 7);
    check_eq("t3 fr", fr1, 1);
    check_eq("t3 fc", fc1, 1);
    tick();
    check_eq("t3 done", done1, 1);
    check_eq("t3 data end", d1, 0);
    check_eq("t3 framing end", {fr1, fc1}, 0);

    // Overfill, clear-over-write priority, start with empty buffer
    clear_all();
    for (int i = 0; i < 4097; i++) load_one(3'(i));
    check_eq("t4 full", lc1, 4096);
    load_clear = 1'b1; load_en = 1'b1;
    tick();
    load_clear = 1'b0; load_en = 1'b0;
    check_eq("t4 cleared", lc1, 0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy1 || done1) seen++;
    end
    check_eq("t4 empty start", seen, 0);

    // Host inputs poked during playback
    load_one(3'd1); load_one(3'd2); load_one(3'd3); load_one(3'd4);
    play4("t5", 1'b1);
    check_eq("t5 lc after", lc1, 4);

    // Asynchronous reset mid-playback
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check_eq("t6 pre data", d1, 2);
    global_reset = 1'b1;
    #1;
    check_eq("t6 async data", d1, 0);
    check_eq("t6 async ctl", {busy1, done1, cs1, fr1, fc1}, 0);
    check_eq("t6 async lc", lc1, 0);
    tick();
    global_reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done1 || busy1) seen++;
    end
    check_eq("t6 no done", seen, 0);
    load_one(3'd3); load_one(3'd5);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check_eq("t6 s0", {d1, fr1, fc1}, {3'd3, 1'b1, 1'b0});
    tick();
    check_eq("t6 s1", {d1, fr1, fc1}, {3'd5, 1'b0, 1'b1});
    tick();
    check_eq("t6 done", done1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
